sema_bank: RTL
==============

SEMA_BANK -- requirements
Module: sema_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent semaphore channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the per-channel token counter width (1..8).
REQ-003 The block SHALL have parameter MAX_CNT, default 2**CNT_W-1, giving the per-channel token ceiling (1..2**CNT_W-1).
REQ-004 The block SHALL have parameter INIT_CNT, default 0, giving the counter value loaded at reset (0..MAX_CNT).
REQ-005 The block SHALL have parameter RST_PRIO, default 1; when 1, a flush wins over a simultaneous release; when 0, a release wins over a simultaneous flush.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 acq_req  input  N_CH  per-channel acquire request, level, sampled every rising edge.
REQ-009 rel  input  N_CH  per-channel release, one token returned per sampled cycle.
REQ-010 flush  input  N_CH  per-channel synchronous clear of the token counter to 0.
REQ-011 err_clr  input  1  synchronous clear of all sticky error bits.
REQ-012 acq_ack  output  N_CH  registered, one-cycle pulse per granted acquisition.
REQ-013 count  output  N_CH*CNT_W  registered token counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 avail  output  N_CH  registered; bit i is 1 iff count[i] > 0.
REQ-015 err_ovf  output  N_CH  sticky; set by a release that would exceed MAX_CNT.
REQ-016 err_udf  output  N_CH  sticky; set by a release issued while a flush is pending or winning.

Function
REQ-017 Channels SHALL be fully independent; there is no cross-channel arbitration.
REQ-018 At each edge, per channel: effective count c = count[i] + rel[i] (before the ceiling check); an acquisition is granted iff acq_req[i]=1 and c > 0.
REQ-019 A granted acquisition SHALL decrement the effective count by 1 and SHALL assert acq_ack[i] for exactly the following cycle.
REQ-020 An ungranted acq_req SHALL leave count and acq_ack unchanged (acq_ack=0) and SHALL be retried on every subsequent edge while held.
REQ-021 acq_req held high across consecutive edges SHALL be treated as one new request per edge, giving up to one grant per cycle; the requester deasserts acq_req in the acq_ack cycle if it wants one token.
REQ-022 Simultaneous rel and acq_req at count 0 SHALL grant the acquisition, leave count at 0, and pulse acq_ack.
REQ-023 Simultaneous rel and acq_req at count MAX_CNT SHALL grant the acquisition, leave count at MAX_CNT, and SHALL NOT set err_ovf.
REQ-024 A rel with no grant at count MAX_CNT SHALL saturate count at MAX_CNT and set err_ovf[i].
REQ-025 flush[i]=1 SHALL load count[i]=0 and suppress any grant on that edge (acq_ack=0), regardless of RST_PRIO.
REQ-026 With RST_PRIO=1, flush plus rel SHALL give count 0 and set err_udf[i]; with RST_PRIO=0, it SHALL give count 1 (the release token survives) with no grant and no error.
REQ-027 err_clr SHALL clear all err_ovf and err_udf bits on that edge; a new error event on the same edge SHALL win, leaving the bit set.
REQ-028 avail SHALL be updated on the same edge as count and SHALL always equal (count>0) per channel.
REQ-029 Count arithmetic SHALL be unsigned CNT_W bits; no value outside 0..MAX_CNT SHALL ever be stored.

Reset
REQ-030 reset_n low SHALL asynchronously set count=INIT_CNT for every channel, avail=(INIT_CNT>0), and acq_ack=0, err_ovf=0, err_udf=0.
REQ-031 An acq_ack pulse in flight at reset assertion SHALL be cancelled immediately.
REQ-032 The first state change after reset_n deassertion SHALL occur at the first rising edge that samples reset_n high.

Verification
REQ-033 Reset, INIT_CNT=0; ch0 acq_req=1 for 3 cycles -> acq_ack=0 throughout, count0=0, avail0=0.
REQ-034 ch1 rel pulsed 3 cycles, then acq_req held 4 cycles -> count1 3,2,1,0; acq_ack1 high exactly 3 consecutive cycles.
REQ-035 CNT_W=2, MAX_CNT=3: 5 rel pulses on ch2 -> count2=3, err_ovf2=1 after 4th pulse; err_clr -> err_ovf2=0, count2=3.
REQ-036 ch3 count=0, rel and acq_req in the same cycle -> acq_ack3=1 next cycle, count3=0.
REQ-037 ch0 count=2, flush+rel+acq_req same cycle: RST_PRIO=1 -> count0=0, err_udf0=1, acq_ack0=0; RST_PRIO=0 -> count0=1, err_udf0=0, acq_ack0=0.
REQ-038 INIT_CNT=2; reset_n asserted mid-run during an acq_ack pulse -> acq_ack=0 immediately, all counts=2, avail all 1, errors 0.

Source files
------------

// File: rtl/sema_bank.sv
// sema_bank: bank of independent counting semaphores.
// Per-channel acquire/release/flush with sticky error flags.
module sema_bank #(
   parameter int N_CH     = 4,
   parameter int CNT_W    = 4,
   parameter int MAX_CNT  = 2**CNT_W-1,
   parameter int INIT_CNT = 0,
   parameter bit RST_PRIO = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_CH-1:0]       acq_req,
   input  logic [N_CH-1:0]       rel,
   input  logic [N_CH-1:0]       flush,
   input  logic                  err_clr,
   output logic [N_CH-1:0]       acq_ack,
   output logic [N_CH*CNT_W-1:0] count,
   output logic [N_CH-1:0]       avail,
   output logic [N_CH-1:0]       err_ovf,
   output logic [N_CH-1:0]       err_udf
);

   localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(MAX_CNT);
   localparam logic [CNT_W:0]   ONE_X  = (CNT_W+1)'(1);
   localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_CNT);
   localparam logic             INIT_A = (INIT_CNT > 0);

   logic [N_CH*CNT_W-1:0] cnt_d;
   logic [N_CH-1:0]       ack_d;
   logic [N_CH-1:0]       av_d;
   logic [N_CH-1:0]       ovf_ev;
   logic [N_CH-1:0]       udf_ev;
   logic [CNT_W:0]        eff;
   logic [CNT_W:0]        nxt;

   // next-state per channel: release, grant, flush, then ceiling clamp
   always_comb begin
      cnt_d  = '0;
      ack_d  = '0;
      av_d   = '0;
      ovf_ev = '0;
      udf_ev = '0;
      eff    = '0;
      nxt    = '0;
      for (int i = 0; i < N_CH; i++) begin
         eff = {1'b0, count[i*CNT_W +: CNT_W]}
             + (CNT_W+1)'(rel[i]);
         nxt = eff;
         if (flush[i]) begin
            if (RST_PRIO) begin
               nxt       = '0;
               udf_ev[i] = rel[i];
            end else begin
               nxt = rel[i] ? ONE_X : '0;
            end
         end else if (acq_req[i] && (eff != '0)) begin
            ack_d[i] = 1'b1;
            nxt      = eff - ONE_X;
         end
         if (nxt > MAX_X) begin
            nxt       = MAX_X;
            ovf_ev[i] = 1'b1;
         end
         cnt_d[i*CNT_W +: CNT_W] = nxt[CNT_W-1:0];
         av_d[i] = (nxt != '0);
      end
   end

   // state registers; a new error event outranks err_clr
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count   <= {N_CH{INIT_V}};
         avail   <= {N_CH{INIT_A}};
         acq_ack <= '0;
         err_ovf <= '0;
         err_udf <= '0;
      end else begin
         count   <= cnt_d;
         avail   <= av_d;
         acq_ack <= ack_d;
         err_ovf <= (err_ovf & ~{N_CH{err_clr}}) | ovf_ev;
         err_udf <= (err_udf & ~{N_CH{err_clr}}) | udf_ev;
      end
   end

endmodule
